// File: rtl/seq_detector_prog_if.sv
// Bundle of stream, configuration and status signals for seq_detector_prog.
// The master side drives the stream and config; the slave side is the detector.
interface seq_detector_prog_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
);
    localparam int LW = $clog2(MAX_LEN + 1);

    logic               en;
    logic               x;
    logic               cfg_we;
    logic [MAX_LEN-1:0] cfg_pat;
    logic [LW-1:0]      cfg_len;
    logic               cfg_overlap;
    logic               y;
    logic [CNT_W-1:0]   match_cnt;
    logic               cnt_sat;
    logic               cfg_err;

    modport master (
        output en, x, cfg_we, cfg_pat, cfg_len, cfg_overlap,
        input  y, match_cnt, cnt_sat, cfg_err
    );

    modport slave (
        input  en, x, cfg_we, cfg_pat, cfg_len, cfg_overlap,
        output y, match_cnt, cnt_sat, cfg_err
    );
endinterface

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial pattern detector with a Mealy match flag,
// overlap control, input qualifier and a saturating match counter.
module seq_detector_prog #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] DEFAULT_PAT = MAX_LEN'(8'b0000_0110),
    parameter int                 DEFAULT_LEN = 4
) (
    input logic                clk,
    input logic                rst,
    seq_detector_prog_if.slave bus
);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [MAX_LEN-1:0] pat;
    logic [LW-1:0]      len;
    logic               overlap;
    logic [MAX_LEN-1:0] hist;
    logic [LW-1:0]      fill;
    logic [CNT_W-1:0]   cnt;
    logic               sat;
    logic               err;

    logic [MAX_LEN-1:0] mask;
    logic [MAX_LEN-1:0] window;
    logic [LW:0]        fill_p1;
    logic               hist_ok;
    logic               match;
    logic               len_ok;
    logic               cfg_accept;
    logic               cfg_reject;
    logic               shift_en;
    logic [LW-1:0]      fill_next;
    logic [CNT_W-1:0]   cnt_next;

    // Only the low len bits of the pattern take part in the compare.
    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len));
        end
    end

    assign window  = {hist[MAX_LEN-2:0], bus.x};
    assign fill_p1 = {1'b0, fill} + (LW+1)'(1);
    assign hist_ok = fill_p1 >= {1'b0, len};

    assign match = bus.en & ~bus.cfg_we & ~rst & hist_ok
                 & ((window & mask) == (pat & mask));

    assign len_ok     = (bus.cfg_len != '0)
                      && (bus.cfg_len <= LW'(MAX_LEN));
    assign cfg_accept = bus.cfg_we & len_ok;
    assign cfg_reject = bus.cfg_we & ~len_ok;
    assign shift_en   = bus.en & ~bus.cfg_we;

    // Next history fill: cleared by a new config or a non-overlap match.
    always_comb begin
        fill_next = fill;
        if (cfg_accept) begin
            fill_next = '0;
        end else if (shift_en) begin
            if (match && !overlap) begin
                fill_next = '0;
            end else if (fill != LW'(MAX_LEN)) begin
                fill_next = fill + LW'(1);
            end
        end
    end

    // Next counter value: cleared by a new config, saturates on matches.
    always_comb begin
        cnt_next = cnt;
        if (cfg_accept) begin
            cnt_next = '0;
        end else if (match && (cnt != CNT_MAX)) begin
            cnt_next = cnt + CNT_W'(1);
        end
    end

    // Configuration registers, loaded only by a valid write.
    always_ff @(posedge clk) begin
        if (rst) begin
            pat     <= DEFAULT_PAT;
            len     <= LW'(DEFAULT_LEN);
            overlap <= 1'b1;
        end else if (cfg_accept) begin
            pat     <= bus.cfg_pat;
            len     <= bus.cfg_len;
            overlap <= bus.cfg_overlap;
        end
    end

    // Shift history on every qualified bit; fill says how much is valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist <= '0;
        end else if (shift_en) begin
            hist <= window;
        end
    end

    // History fill level.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill <= '0;
        end else begin
            fill <= fill_next;
        end
    end

    // Match counter and its registered saturation flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            sat <= 1'b0;
        end else begin
            cnt <= cnt_next;
            sat <= &cnt_next;
        end
    end

    // One-cycle error pulse after a rejected config write.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else begin
            err <= cfg_reject;
        end
    end

    assign bus.y         = match;
    assign bus.match_cnt = cnt;
    assign bus.cnt_sat   = sat;
    assign bus.cfg_err   = err;
endmodule

// File: doc/seq_detector_prog.md
Name: seq_detector_prog

Overview:
- Runtime-programmable serial bit-pattern detector with Mealy output. It is the parametrised successor of the fixed 4-bit "0110" overlapping detector FSM.
- Adds programmable pattern and length (1..MAX_LEN), an overlap/non-overlap mode, an input-valid qualifier, and a saturating match counter.
- Sits on a 1-bit serial stream from upstream logic; y feeds downstream control the same cycle.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- CNT_W, 8, match counter width.
- DEFAULT_PAT, 8'b0000_0110, reset pattern, LSB-aligned, MAX_LEN bits.
- DEFAULT_LEN, 4, reset pattern length (1..MAX_LEN).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  x valid this cycle; when low, no state change and y=0.
- x  in  1  serial data bit.
- cfg_we  in  1  one-cycle configuration write strobe.
- cfg_pat  in  MAX_LEN  new pattern; bit [len-1] is the first-received bit, bit 0 the last.
- cfg_len  in  $clog2(MAX_LEN+1)  new pattern length.
- cfg_overlap  in  1  1 = overlapping matches allowed, 0 = history cleared after a match.
- y  out  1  Mealy match flag, combinational from state and current x.
- match_cnt  out  CNT_W  number of matches since reset or the last accepted config write.
- cnt_sat  out  1  match_cnt is all-ones.
- cfg_err  out  1  registered one-cycle pulse after a rejected config write.

Behaviour:
- Reset (rst=1 at edge):
  - pat=DEFAULT_PAT, len=DEFAULT_LEN, overlap=1.
  - hist=0, fill=0, match_cnt=0, cnt_sat=0, cfg_err=0.
  - y forced 0 while rst=1.
  - Reset mid-stream discards all partial history.
- State: hist[MAX_LEN-1:0] (hist[0] = newest accepted bit) and fill (count of valid history bits, saturating at MAX_LEN).
- Match condition, combinational:
  - match = en & !cfg_we & !rst & (fill >= len-1) & ({hist[len-2:0], x} == pat[len-1:0]).
  - For len=1: match = en & (x == pat[0]), independent of fill.
  - y = match. Latency 0: y asserts in the same cycle as the final pattern bit.
- Clock edge, cfg_we=0, en=1:
  - If match & !overlap: fill<=0 (hist contents are don't-care).
  - Otherwise: hist<={hist[MAX_LEN-2:0], x}, fill<=min(fill+1, MAX_LEN).
  - If match: match_cnt<=match_cnt+1, saturating at 2^CNT_W-1, no wrap. cnt_sat is registered and follows the counter.
- Clock edge, en=0: hist, fill and match_cnt hold; y=0.
- Clock edge, cfg_we=1, takes priority over en:
  - If 1 <= cfg_len <= MAX_LEN: latch pat, len, overlap; fill<=0; match_cnt<=0; cnt_sat<=0; the x bit in that cycle is dropped.
  - Otherwise (len 0 or > MAX_LEN): config registers, fill and counter unchanged; x dropped; cfg_err<=1 for the next cycle only.
  - cfg_err is 0 in every cycle not following a rejected write.
- Pattern bits above len-1 are ignored.
- Overlap semantics: in overlap mode, every position whose last len bits equal the pattern produces a match, including matches sharing bits with a previous match.

Test Plan:
- Defaults (0110, overlap), en=1, stream x=0,1,1,0,1,1,0 -> y=1 on 4th and 7th bits only; match_cnt=2 afterwards.
- cfg_we with pat=0110, len=4, overlap=0, then same stream -> y=1 on 4th bit only; match_cnt=1. Appending 0,1,1,0 -> y on the last bit; match_cnt=2.
- Stream 0,1 then en=0 for 3 cycles with x toggling, then en=1 with 1,0 -> y=0 during the gap; y=1 on the final 0; match_cnt=1.
- cfg_len=0, and separately cfg_len=MAX_LEN+1 -> cfg_err=1 for exactly one cycle; pattern behaviour and match_cnt unchanged. cfg_len=1, pat[0]=1, stream 1,1,0,1 -> y=1,1,0,1.
- Build with CNT_W=3, len=1, pat=1, x=1 for 10 cycles -> match_cnt reads 1..7 then holds 7; cnt_sat=1 from the cycle after the 7th match.
- Stream 0,1,1 then rst=1 for one cycle, then 0 -> y=0, match_cnt=0. Full 0,1,1,0 afterwards -> y=1 on the last bit.
